// File: rtl/oam_access_ctrl.sv
// oam_access_ctrl: CPU side of the sprite OAM ($2102/$2103/$2104/$2138).
// Holds one pending register op and slots RAM accesses around the sprite engine.
module oam_access_ctrl #(
    parameter bit RELOAD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_we,
    input  logic        reg_re,
    input  logic [5:0]  reg_sel,
    input  logic [7:0]  reg_din,
    output logic        reg_ready,
    output logic [7:0]  reg_dout,
    output logic        reg_rvalid,
    output logic        obj_prio_rot,
    input  logic        vblank_start,
    input  logic        force_blank,
    input  logic        spr_req,
    input  logic [7:0]  spr_lo_addr,
    input  logic [4:0]  spr_hi_addr,
    output logic [7:0]  lo_addr,
    output logic [15:0] lo_din,
    output logic        lo_we,
    input  logic [15:0] lo_dout,
    output logic [4:0]  hi_addr,
    output logic [7:0]  hi_din,
    output logic        hi_we,
    input  logic [7:0]  hi_dout
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RDW
    } state_t;

    typedef enum logic [1:0] {
        OP_ADDL,
        OP_ADDH,
        OP_DATA,
        OP_READ
    } op_t;

    state_t state, state_n;
    op_t    op_q, op_n;

    logic [7:0] din_q;
    logic [9:0] baddr;
    logic [8:0] reload;
    logic [8:0] reload_new;
    logic [7:0] lbuf;
    logic       rd_odd_q;
    logic       rd_hi_q;

    logic hit_lo, hit_hi, hit_data, hit_read;
    logic strobe;
    logic reg_op;
    logic slot;
    logic reg_done;
    logic reload_hit;
    logic data_op;
    logic read_op;

    assign hit_lo   = reg_we && (reg_sel == 6'h02);
    assign hit_hi   = reg_we && (reg_sel == 6'h03);
    assign hit_data = reg_we && (reg_sel == 6'h04);
    assign hit_read = reg_re && (reg_sel == 6'h38);

    assign strobe = (state == IDLE)
                 && (hit_lo || hit_hi || hit_data || hit_read);

    assign reg_op   = (op_q == OP_ADDL) || (op_q == OP_ADDH);
    assign data_op  = (op_q == OP_DATA);
    assign read_op  = (op_q == OP_READ);
    assign reg_done = (state == PEND) && reg_op;
    assign slot     = (state == PEND) && !reg_op && !spr_req;

    assign reload_hit = RELOAD_EN && vblank_start && !force_blank;

    assign reload_new = (op_q == OP_ADDH)
                      ? {din_q[0], reload[7:0]}
                      : {reload[8], din_q};

    always_comb begin
        op_n = op_q;
        unique case (1'b1)
            hit_lo:   op_n = OP_ADDL;
            hit_hi:   op_n = OP_ADDH;
            hit_data: op_n = OP_DATA;
            hit_read: op_n = OP_READ;
            default:  op_n = op_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        reg_ready = (state == IDLE);
        lo_addr   = baddr[8:1];
        hi_addr   = baddr[4:0];
        lo_din    = {din_q, lbuf};
        hi_din    = din_q;
        lo_we     = 1'b0;
        hi_we     = 1'b0;

        case (state)
            IDLE: begin
                if (strobe) begin
                    state_n = PEND;
                end
            end
            PEND: begin
                if (reg_done) begin
                    state_n = IDLE;
                end else if (slot) begin
                    state_n = read_op ? RDW : IDLE;
                end
            end
            RDW: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Sprite engine owns both ports; a reset cycle must never write.
        if (spr_req) begin
            lo_addr = spr_lo_addr;
            hi_addr = spr_hi_addr;
        end else if (slot && data_op && !reset) begin
            if (baddr[9]) begin
                hi_we = 1'b1;
            end else if (baddr[0]) begin
                lo_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q         <= OP_ADDL;
            din_q        <= 8'h00;
            baddr        <= 10'h000;
            reload       <= 9'h000;
            lbuf         <= 8'h00;
            obj_prio_rot <= 1'b0;
            rd_odd_q     <= 1'b0;
            rd_hi_q      <= 1'b0;
            reg_dout     <= 8'h00;
            reg_rvalid   <= 1'b0;
        end else begin
            if (strobe) begin
                op_q  <= op_n;
                din_q <= reg_din;
            end

            // Address writes beat vblank reload, which beats the increment.
            if (reg_done) begin
                reload <= reload_new;
                baddr  <= {reload_new, 1'b0};
                if (op_q == OP_ADDH) begin
                    obj_prio_rot <= din_q[7];
                end
            end else if (reload_hit) begin
                baddr <= {reload, 1'b0};
            end else if (slot) begin
                baddr <= baddr + 10'd1;
            end

            if (slot && data_op && !baddr[9] && !baddr[0]) begin
                lbuf <= din_q;
            end

            if (slot && read_op) begin
                rd_odd_q <= baddr[0];
                rd_hi_q  <= baddr[9];
            end

            if (state == RDW) begin
                if (rd_hi_q) begin
                    reg_dout <= hi_dout;
                end else if (rd_odd_q) begin
                    reg_dout <= lo_dout[15:8];
                end else begin
                    reg_dout <= lo_dout[7:0];
                end
            end

            reg_rvalid <= (state == RDW);
        end
    end

endmodule

// File: tb/tb_oam_access_ctrl.sv
// tb_oam_access_ctrl: directed and randomized checks of the OAM access
// controller against an address/byte-level model of the OAM tables.
module tb_oam_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_we, reg_re;
    logic [5:0]  reg_sel;
    logic [7:0]  reg_din, reg_dout;
    logic        reg_ready, reg_rvalid, obj_prio_rot;
    logic        vblank_start, force_blank, spr_req;
    logic [7:0]  spr_lo_addr;
    logic [4:0]  spr_hi_addr;
    logic [7:0]  lo_addr;
    logic [15:0] lo_din, lo_dout;
    logic        lo_we;
    logic [4:0]  hi_addr;
    logic [7:0]  hi_din, hi_dout;
    logic        hi_we;

    always #5 clk = ~clk;

    oam_access_ctrl #(.RELOAD_EN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .reg_we(reg_we), .reg_re(reg_re), .reg_sel(reg_sel), .reg_din(reg_din),
        .reg_ready(reg_ready), .reg_dout(reg_dout), .reg_rvalid(reg_rvalid),
        .obj_prio_rot(obj_prio_rot),
        .vblank_start(vblank_start), .force_blank(force_blank),
        .spr_req(spr_req), .spr_lo_addr(spr_lo_addr), .spr_hi_addr(spr_hi_addr),
        .lo_addr(lo_addr), .lo_din(lo_din), .lo_we(lo_we), .lo_dout(lo_dout),
        .hi_addr(hi_addr), .hi_din(hi_din), .hi_we(hi_we), .hi_dout(hi_dout)
    );

    // OAM block RAMs with one-cycle synchronous read
    logic [15:0] lo_ram [256];
    logic [7:0]  hi_ram [32];
    logic [15:0] fill_lo [256];
    logic [7:0]  fill_hi [32];
    logic        fill;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) lo_ram[i] <= fill_lo[i];
            for (int i = 0; i < 32; i++) hi_ram[i] <= fill_hi[i];
        end else begin
            if (lo_we) lo_ram[lo_addr] <= lo_din;
            if (hi_we) hi_ram[hi_addr] <= hi_din;
        end
        lo_dout <= lo_ram[lo_addr];
        hi_dout <= hi_ram[hi_addr];
    end

    int          n_lo_we = 0, n_hi_we = 0, mux_err = 0;
    logic [7:0]  last_lo_addr;
    logic [15:0] last_lo_din;
    logic [4:0]  last_hi_addr;
    logic [7:0]  last_hi_din;

    always @(negedge clk) begin
        if (lo_we === 1'b1) begin
            n_lo_we      <= n_lo_we + 1;
            last_lo_addr <= lo_addr;
            last_lo_din  <= lo_din;
        end
        if (hi_we === 1'b1) begin
            n_hi_we      <= n_hi_we + 1;
            last_hi_addr <= hi_addr;
            last_hi_din  <= hi_din;
        end
        if (spr_req === 1'b1 && (lo_we !== 1'b0 || hi_we !== 1'b0 ||
            lo_addr !== spr_lo_addr || hi_addr !== spr_hi_addr))
            mux_err <= mux_err + 1;
    end

    int n_cmp = 0, n_fail = 0, n_timeouts = 0;

    // Reference model: OAM as byte-addressed tables
    int m_baddr, m_reload, m_lbuf, m_prio;
    int m_lo [256];
    int m_hi [32];

    task automatic m_write(input int sel, input int d);
        if (sel == 2) begin
            m_reload = (m_reload / 256) * 256 + d;
            m_baddr  = m_reload * 2;
        end else if (sel == 3) begin
            m_reload = (d % 2) * 256 + m_reload % 256;
            m_prio   = d / 128;
            m_baddr  = m_reload * 2;
        end else if (sel == 4) begin
            if (m_baddr < 512) begin
                if (m_baddr % 2 == 0) m_lbuf = d;
                else m_lo[m_baddr / 2] = d * 256 + m_lbuf;
            end else begin
                m_hi[m_baddr % 32] = d;
            end
            m_baddr = (m_baddr + 1) % 1024;
        end
    endtask

    task automatic m_read(output int r);
        if (m_baddr < 512)
            r = (m_baddr % 2 == 1) ? m_lo[m_baddr / 2] / 256 : m_lo[m_baddr / 2] % 256;
        else
            r = m_hi[m_baddr % 32];
        m_baddr = (m_baddr + 1) % 1024;
    endtask

    task automatic rand_spr();
        spr_req     = ($urandom_range(0, 2) == 0);
        spr_lo_addr = 8'($urandom);
        spr_hi_addr = 5'($urandom);
    endtask

    // Issue one strobe and wait (bounded) for ready or read data.
    task automatic do_access(input bit is_rd, input logic [5:0] sel,
                             input logic [7:0] din, input bit rnd, input bit vb1,
                             output logic [7:0] rd, output int lat);
        int cyc;
        cyc = 0;
        reg_we = !is_rd; reg_re = is_rd; reg_sel = sel; reg_din = din;
        if (rnd) rand_spr();
        @(posedge clk); #1;
        reg_we = 1'b0; reg_re = 1'b0;
        if (vb1) begin vblank_start = 1'b1; force_blank = 1'b0; end
        if (rnd) rand_spr();
        while (!(is_rd ? reg_rvalid : reg_ready) && cyc < 60) begin
            @(posedge clk); #1;
            vblank_start = 1'b0;
            cyc++;
            if (rnd) rand_spr();
        end
        vblank_start = 1'b0;
        if (cyc >= 60) n_timeouts++;
        rd  = reg_dout;
        lat = cyc + 1;
    endtask

    task automatic wr(input int sel, input int d, input bit rnd);
        logic [7:0] rd;
        int lat;
        do_access(1'b0, 6'(sel), 8'(d), rnd, 1'b0, rd, lat);
        m_write(sel, d);
    endtask

    task automatic rdop(input bit rnd, output logic [7:0] got, output int exp, output int lat);
        do_access(1'b1, 6'h38, 8'h00, rnd, 1'b0, got, lat);
        m_read(exp);
    endtask

    task automatic vb(input bit fb);
        vblank_start = 1'b1; force_blank = fb;
        @(posedge clk); #1;
        vblank_start = 1'b0; force_blank = 1'b0;
        if (!fb) m_baddr = m_reload * 2;
    endtask

    task automatic test_reset();
        logic [7:0] got; int exp, lat;
        for (int i = 0; i < 256; i++) fill_lo[i] = 16'($urandom);
        for (int i = 0; i < 32; i++) fill_hi[i] = 8'($urandom);
        reset = 1'b1; fill = 1'b1;
        repeat (3) @(posedge clk);
        #1; fill = 1'b0; reset = 1'b0;
        for (int i = 0; i < 256; i++) m_lo[i] = int'(fill_lo[i]);
        for (int i = 0; i < 32; i++) m_hi[i] = int'(fill_hi[i]);
        m_baddr = 0; m_reload = 0; m_lbuf = 0; m_prio = 0;
        @(negedge clk);
        n_cmp++; if (reg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", reg_ready); end
        n_cmp++; if (reg_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got %b exp 0", reg_rvalid); end
        n_cmp++; if (reg_dout !== 8'h00) begin n_fail++; $display("FAIL rst_dout got %h exp 00", reg_dout); end
        n_cmp++; if (obj_prio_rot !== 1'b0) begin n_fail++; $display("FAIL rst_prio got %b exp 0", obj_prio_rot); end
        n_cmp++; if (lo_we !== 1'b0 || hi_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b%b exp 00", lo_we, hi_we); end
        @(posedge clk); #1;
        rdop(1'b0, got, exp, lat);
        n_cmp++; if (got !== 8'(exp)) begin n_fail++; $display("FAIL rst_baddr_read got %h exp %h", got, 8'(exp)); end
    endtask

    task automatic test_lo_write();
        int n0, exp, lat;
        logic [7:0] got;
        wr(2, 8'h05, 1'b0);
        wr(3, 8'h00, 1'b0);
        n0 = n_lo_we;
        wr(4, 8'h11, 1'b0);
        wr(4, 8'h22, 1'b0);
        n_cmp++; if (n_lo_we - n0 != 1) begin n_fail++; $display("FAIL lo_we_count got %0d exp 1", n_lo_we - n0); end
        n_cmp++; if (last_lo_addr !== 8'h05) begin n_fail++; $display("FAIL lo_addr got %h exp 05", last_lo_addr); end
        n_cmp++; if (last_lo_din !== 16'h2211) begin n_fail++; $display("FAIL lo_din got %h exp 2211", last_lo_din); end
        rdop(1'b0, got, exp, lat);
        n_cmp++; if (got !== 8'(exp)) begin n_fail++; $display("FAIL lo_next_read got %h exp %h", got, 8'(exp)); end
    endtask

    task automatic test_hi_write();
        int n0, exp, lat;
        logic [7:0] got;
        wr(3, 8'h80, 1'b0);
        n_cmp++; if (obj_prio_rot !== 1'b1) begin n_fail++; $display("FAIL prio_set got %b exp 1", obj_prio_rot); end
        wr(3, 8'h01, 1'b0);
        n_cmp++; if (obj_prio_rot !== 1'b0) begin n_fail++; $display("FAIL prio_clr got %b exp 0", obj_prio_rot); end
        wr(2, 8'h00, 1'b0);
        n0 = n_hi_we;
        wr(4, 8'hAB, 1'b0);
        n_cmp++; if (n_hi_we - n0 != 1) begin n_fail++; $display("FAIL hi_we_count got %0d exp 1", n_hi_we - n0); end
        n_cmp++; if (last_hi_addr !== 5'd0) begin n_fail++; $display("FAIL hi_addr got %h exp 00", last_hi_addr); end
        n_cmp++; if (last_hi_din !== 8'hAB) begin n_fail++; $display("FAIL hi_din got %h exp ab", last_hi_din); end
        rdop(1'b0, got, exp, lat);
        n_cmp++; if (got !== 8'(exp)) begin n_fail++; $display("FAIL hi_read got %h exp %h", got, 8'(exp)); end
        n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL read_latency got %0d exp 3", lat); end
        @(posedge clk); #1;
        n_cmp++; if (reg_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse got %b exp 0", reg_rvalid); end
        n_cmp++; if (reg_dout !== 8'(exp)) begin n_fail++; $display("FAIL dout_hold got %h exp %h", reg_dout, 8'(exp)); end
    endtask

    task automatic test_contention();
        int n0;
        wr(3, 8'h00, 1'b0);
        wr(2, 8'h30, 1'b0);
        wr(4, 8'h77, 1'b0);
        n0 = n_lo_we;
        spr_req = 1'b1; spr_lo_addr = 8'($urandom); spr_hi_addr = 5'($urandom);
        reg_we = 1'b1; reg_sel = 6'h04; reg_din = 8'h88;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_cmp++; if (reg_ready !== 1'b0) begin n_fail++; $display("FAIL spr_ready cyc %0d got %b exp 0", i, reg_ready); end
            end
            @(posedge clk); #1;
            reg_we = 1'b0;
            spr_lo_addr = 8'($urandom); spr_hi_addr = 5'($urandom);
        end
        n_cmp++; if (n_lo_we != n0) begin n_fail++; $display("FAIL spr_no_we got %0d exp 0", n_lo_we - n0); end
        spr_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (lo_we !== 1'b1) begin n_fail++; $display("FAIL slot_we got %b exp 1", lo_we); end
        n_cmp++; if (lo_addr !== 8'h30) begin n_fail++; $display("FAIL slot_addr got %h exp 30", lo_addr); end
        n_cmp++; if (lo_din !== 16'h8877) begin n_fail++; $display("FAIL slot_din got %h exp 8877", lo_din); end
        @(posedge clk); #1;
        n_cmp++; if (reg_ready !== 1'b1) begin n_fail++; $display("FAIL slot_ready got %b exp 1", reg_ready); end
        m_write(4, 8'h88);
    endtask

    task automatic test_wrap();
        int n0, exp, lat;
        logic [7:0] got;
        wr(3, 8'h01, 1'b0);
        wr(2, 8'hFF, 1'b0);
        wr(4, 8'h33, 1'b0);
        n0 = n_hi_we;
        wr(4, 8'h5A, 1'b0);
        n_cmp++; if (n_hi_we - n0 != 1) begin n_fail++; $display("FAIL wrap_we got %0d exp 1", n_hi_we - n0); end
        n_cmp++; if (last_hi_addr !== 5'd31) begin n_fail++; $display("FAIL wrap_addr got %0d exp 31", last_hi_addr); end
        n_cmp++; if (last_hi_din !== 8'h5A) begin n_fail++; $display("FAIL wrap_din got %h exp 5a", last_hi_din); end
        rdop(1'b0, got, exp, lat);
        n_cmp++; if (got !== 8'(exp)) begin n_fail++; $display("FAIL wrap_read got %h exp %h", got, 8'(exp)); end
    endtask

    task automatic test_vblank();
        int exp, lat;
        logic [7:0] got, d;
        wr(3, 8'h00, 1'b0);
        wr(2, 8'h10, 1'b0);
        for (int i = 0; i < 3; i++) wr(4, int'($urandom_range(0, 255)), 1'b0);
        vb(1'b0);
        rdop(1'b0, got, exp, lat);
        n_cmp++; if (got !== 8'(exp)) begin n_fail++; $display("FAIL vb_reload got %h exp %h", got, 8'(exp)); end
        vb(1'b1);
        rdop(1'b0, got, exp, lat);
        n_cmp++; if (got !== 8'(exp)) begin n_fail++; $display("FAIL vb_forceblank got %h exp %h", got, 8'(exp)); end
        do_access(1'b1, 6'h38, 8'h00, 1'b0, 1'b1, got, lat);
        m_read(exp);
        m_baddr = m_reload * 2;
        n_cmp++; if (got !== 8'(exp)) begin n_fail++; $display("FAIL vb_slot_read got %h exp %h", got, 8'(exp)); end
        rdop(1'b0, got, exp, lat);
        n_cmp++; if (got !== 8'(exp)) begin n_fail++; $display("FAIL vb_beats_inc got %h exp %h", got, 8'(exp)); end
        do_access(1'b0, 6'h02, 8'h20, 1'b0, 1'b1, d, lat);
        m_write(2, 8'h20);
        rdop(1'b0, got, exp, lat);
        n_cmp++; if (got !== 8'(exp)) begin n_fail++; $display("FAIL addr_beats_vb got %h exp %h", got, 8'(exp)); end
    endtask

    task automatic test_reset_mid();
        int n0, h0, exp, lat;
        logic [7:0] got;
        wr(3, 8'h80, 1'b0);
        wr(2, 8'h40, 1'b0);
        wr(4, 8'h12, 1'b0);
        rdop(1'b0, got, exp, lat);
        wr(3, 8'h80, 1'b0);
        wr(4, 8'h12, 1'b0);
        n0 = n_lo_we; h0 = n_hi_we;
        spr_req = 1'b1; reg_we = 1'b1; reg_sel = 6'h04; reg_din = 8'h34;
        @(posedge clk); #1;
        reg_we = 1'b0; spr_req = 1'b0; reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (lo_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_we got %b exp 0", lo_we); end
        @(posedge clk); #1;
        reset = 1'b0;
        m_baddr = 0; m_reload = 0; m_lbuf = 0; m_prio = 0;
        n_cmp++; if (reg_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", reg_ready); end
        n_cmp++; if (reg_dout !== 8'h00 || reg_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd got %h/%b exp 00/0", reg_dout, reg_rvalid); end
        n_cmp++; if (obj_prio_rot !== 1'b0) begin n_fail++; $display("FAIL rstmid_prio got %b exp 0", obj_prio_rot); end
        n_cmp++; if (lo_we !== 1'b0 || hi_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_we2 got %b%b exp 00", lo_we, hi_we); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (n_lo_we != n0 || n_hi_we != h0) begin n_fail++; $display("FAIL rstmid_nowrite got %0d exp 0", n_lo_we - n0 + n_hi_we - h0); end
        rdop(1'b0, got, exp, lat);
        n_cmp++; if (got !== 8'(exp)) begin n_fail++; $display("FAIL rstmid_baddr got %h exp %h", got, 8'(exp)); end
    endtask

    task automatic test_random();
        int p, exp, lat;
        logic [7:0] got;
        logic [5:0] s;
        for (int k = 0; k < 200; k++) begin
            p = int'($urandom_range(0, 99));
            if (p < 10) begin
                s = 6'($urandom);
                if (p < 5) begin
                    if (s == 6'h02 || s == 6'h03 || s == 6'h04) s = 6'h38;
                    reg_we = 1'b1;
                end else begin
                    if (s == 6'h38) s = 6'h04;
                    reg_re = 1'b1;
                end
                reg_sel = s; reg_din = 8'($urandom);
                @(posedge clk); #1;
                reg_we = 1'b0; reg_re = 1'b0;
                n_cmp++; if (reg_ready !== 1'b1) begin n_fail++; $display("FAIL ignored_sel %h got %b exp 1", s, reg_ready); end
            end else if (p < 16) begin
                vb(1'($urandom_range(0, 1)));
            end else if (p < 22) begin
                wr(2, int'($urandom_range(0, 255)), 1'b1);
            end else if (p < 28) begin
                wr(3, int'($urandom_range(0, 255)), 1'b1);
            end else if (p < 70) begin
                wr(4, int'($urandom_range(0, 255)), 1'b1);
            end else begin
                rdop(1'b1, got, exp, lat);
                n_cmp++; if (got !== 8'(exp)) begin n_fail++; $display("FAIL rand_read %0d got %h exp %h", k, got, 8'(exp)); end
            end
        end
        spr_req = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (obj_prio_rot !== 1'(m_prio)) begin n_fail++; $display("FAIL rand_prio got %b exp %0d", obj_prio_rot, m_prio); end
    endtask

    task automatic test_final();
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (lo_ram[i] !== 16'(m_lo[i])) bad++;
        for (int i = 0; i < 32; i++) if (hi_ram[i] !== 8'(m_hi[i])) bad++;
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL ram_contents got %0d bad entries exp 0", bad); end
        n_cmp++; if (mux_err != 0) begin n_fail++; $display("FAIL spr_mux got %0d errors exp 0", mux_err); end
        n_cmp++; if (n_timeouts != 0) begin n_fail++; $display("FAIL timeouts got %0d exp 0", n_timeouts); end
    endtask

    initial begin
        reset = 1'b1; fill = 1'b1;
        reg_we = 1'b0; reg_re = 1'b0; reg_sel = 6'h00; reg_din = 8'h00;
        vblank_start = 1'b0; force_blank = 1'b0;
        spr_req = 1'b0; spr_lo_addr = 8'h00; spr_hi_addr = 5'h00;
        test_reset();
        test_lo_write();
        test_hi_write();
        test_contention();
        test_wrap();
        test_vblank();
        test_reset_mid();
        test_random();
        test_final();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
